// File: rtl/ov7670_fb_write_ctrl.sv
// Frame-buffer write sequencer in the OV7670 pixel-clock domain: aligns capture to VSYNC,
// packs RGB565 byte pairs to RGB332 and issues one buffer write per pixel.
module ov7670_fb_write_ctrl #(
  parameter int IMG_W  = 176,
  parameter int IMG_H  = 120,
  parameter int ADDR_W = 15
) (
  input  logic              clk_W,
  input  logic              rst_n,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              cap_en,
  input  logic              snap,
  output logic [ADDR_W-1:0] w_addr,
  output logic [7:0]        w_data,
  output logic              w_en,
  output logic              busy,
  output logic              frame_done,
  output logic              sync_err
);

  localparam int COL_W = $clog2(IMG_W + 1);
  localparam int ROW_W = $clog2(IMG_H + 1);
  localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(IMG_W);
  localparam logic [ROW_W-1:0]  ROW_MAX   = ROW_W'(IMG_H);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(IMG_W);

  typedef enum logic [2:0] {IDLE, ARM, SYNC, CAPTURE, DONE} state_t;

  state_t            state, state_nxt;
  logic              vs_q, hr_q;
  logic [7:0]        d_q;
  logic [7:0]        b1;
  logic [7:0]        pix;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] base;
  logic              byte_phase;
  logic              line_act;
  logic              snap_pend;
  logic              req;

  assign req = cap_en | snap | snap_pend;
  assign pix = {b1[7:5], b1[2:0], d_q[4:3]};

  always_ff @(posedge clk_W) begin
    if (!rst_n) begin
      vs_q <= 1'b0;
      hr_q <= 1'b0;
      d_q  <= 8'd0;
    end else begin
      vs_q <= cam_vsync;
      hr_q <= cam_href;
      d_q  <= cam_data;
    end
  end

  always_ff @(posedge clk_W) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // DONE is entered on vs_q rising, so a follow-on frame skips ARM.
  always_comb begin
    state_nxt  = state;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (req) state_nxt = ARM;
      end
      ARM:     if (vs_q)  state_nxt = SYNC;
      SYNC:    if (!vs_q) state_nxt = CAPTURE;
      CAPTURE: if (vs_q)  state_nxt = DONE;
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = req ? SYNC : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_W) begin
    if (!rst_n) begin
      snap_pend <= 1'b0;
    end else if ((state == IDLE && state_nxt == ARM) || (state == DONE && state_nxt == SYNC)) begin
      snap_pend <= 1'b0;
    end else if (snap && state != IDLE) begin
      snap_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk_W) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      base       <= '0;
      byte_phase <= 1'b0;
      line_act   <= 1'b0;
      b1         <= 8'd0;
      w_en       <= 1'b0;
      w_addr     <= '0;
      w_data     <= 8'd0;
      sync_err   <= 1'b0;
    end else begin
      w_en <= 1'b0;
      case (state)
        SYNC: begin
          if (!vs_q) begin
            col        <= '0;
            row        <= '0;
            base       <= '0;
            byte_phase <= 1'b0;
            line_act   <= 1'b0;
            sync_err   <= 1'b0;
          end
        end
        CAPTURE: begin
          if (!vs_q) begin
            if (hr_q) begin
              line_act   <= 1'b1;
              byte_phase <= ~byte_phase;
              if (!byte_phase) begin
                b1 <= d_q;
              end else if (col < COL_MAX && row < ROW_MAX) begin
                w_en   <= 1'b1;
                w_data <= pix;
                w_addr <= base + ADDR_W'(col);
                col    <= col + COL_W'(1);
              end else begin
                sync_err <= 1'b1;
              end
            end else if (line_act) begin
              // End of a non-empty line; a dangling first byte is an odd-length line.
              line_act   <= 1'b0;
              col        <= '0;
              byte_phase <= 1'b0;
              if (byte_phase) sync_err <= 1'b1;
              if (row < ROW_MAX) begin
                row  <= row + ROW_W'(1);
                base <= base + LINE_STEP;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_fb_write_ctrl.sv
// Bench for ov7670_fb_write_ctrl: a small 4x2 instance for directed corner cases and a
// default-size instance for a full frame, both checked against a frame-level write model.
module tb_ov7670_fb_write_ctrl;

  logic        clk_W = 1'b0;
  logic        rst_n;
  logic        cam_vsync, cam_href;
  logic [7:0]  cam_data;
  logic        cap_en_s, snap_s, cap_en_b, snap_b;
  logic [14:0] w_addr_s, w_addr_b;
  logic [7:0]  w_data_s, w_data_b;
  logic        w_en_s, w_en_b, busy_s, busy_b, frame_done_s, frame_done_b, sync_err_s, sync_err_b;

  int tests = 0;
  int fails = 0;
  int done_s = 0;
  int done_b = 0;
  int d0;
  bit exp_err;
  logic [31:0] act_s[$], exp_s[$], act_b[$], exp_b[$];
  int flen[$];
  logic [7:0] fbytes[$];

  always #5 clk_W = ~clk_W;

  ov7670_fb_write_ctrl #(.IMG_W(4), .IMG_H(2), .ADDR_W(15)) u_small (
    .clk_W(clk_W), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .cap_en(cap_en_s), .snap(snap_s), .w_addr(w_addr_s), .w_data(w_data_s), .w_en(w_en_s),
    .busy(busy_s), .frame_done(frame_done_s), .sync_err(sync_err_s));

  ov7670_fb_write_ctrl #(.IMG_W(176), .IMG_H(120), .ADDR_W(15)) u_big (
    .clk_W(clk_W), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .cap_en(cap_en_b), .snap(snap_b), .w_addr(w_addr_b), .w_data(w_data_b), .w_en(w_en_b),
    .busy(busy_b), .frame_done(frame_done_b), .sync_err(sync_err_b));

  always @(negedge clk_W) begin
    if (w_en_s) act_s.push_back({9'd0, w_addr_s, w_data_s});
    if (w_en_b) act_b.push_back({9'd0, w_addr_b, w_data_b});
    if (frame_done_s) done_s++;
    if (frame_done_b) done_b++;
  end

  task automatic tick();
    @(posedge clk_W);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_all();
    act_s.delete(); exp_s.delete(); act_b.delete(); exp_b.delete();
    flen.delete(); fbytes.delete();
    exp_err = 1'b0;
  endtask

  task automatic add_lines(input int n, input int len, input bit fixed);
    for (int i = 0; i < n; i++) begin
      flen.push_back(len);
      for (int j = 0; j < len; j++)
        fbytes.push_back(fixed ? ((j % 2) ? 8'h1F : 8'hF8) : 8'($urandom));
    end
  endtask

  // Expected writes: pixel p of the li-th non-empty line lands at li*W+p when inside the image.
  task automatic model_frame(input bit big);
    int w, h, pos, li, n;
    logic [7:0] a, b;
    logic [31:0] item;
    w = big ? 176 : 4;
    h = big ? 120 : 2;
    pos = 0;
    li = 0;
    foreach (flen[l]) begin
      n = flen[l];
      if (n != 0) begin
        if (n % 2 != 0) exp_err = 1'b1;
        for (int p = 0; p < n / 2; p++) begin
          if (p < w && li < h) begin
            a = fbytes[pos + 2 * p];
            b = fbytes[pos + 2 * p + 1];
            item = {9'd0, 15'(li * w + p), a[7:5], a[2:0], b[4:3]};
            if (big) exp_b.push_back(item);
            else     exp_s.push_back(item);
          end else begin
            exp_err = 1'b1;
          end
        end
        pos += n;
        li++;
      end
    end
  endtask

  task automatic send_lines();
    int pos;
    pos = 0;
    foreach (flen[l]) begin
      for (int j = 0; j < flen[l]; j++) begin
        cam_href = 1'b1;
        cam_data = fbytes[pos];
        pos++;
        tick();
      end
      cam_href = 1'b0;
      cam_data = 8'($urandom);
      repeat (3) tick();
    end
  endtask

  task automatic vsync_pulse();
    repeat (2) tick();
    cam_vsync = 1'b1;
    repeat (4) tick();
    cam_vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic compare_q(input string tag, input bit big);
    logic [31:0] a[$], e[$];
    int bad, first;
    if (big) begin a = act_b; e = exp_b; end
    else     begin a = act_s; e = exp_s; end
    check({tag, "_count"}, a.size(), e.size());
    bad = 0;
    first = -1;
    for (int i = 0; i < a.size() && i < e.size(); i++) begin
      if (a[i] !== e[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    check({tag, "_mismatches"}, bad, 0);
  endtask

  initial begin
    logic [31:0] item;
    rst_n = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'd0;
    cap_en_s = 1'b0; snap_s = 1'b0; cap_en_b = 1'b0; snap_b = 1'b0;
    repeat (2) tick();
    check("rst_w_en", w_en_s, 0);
    check("rst_w_addr", w_addr_s, 0);
    check("rst_w_data", w_data_s, 0);
    check("rst_busy", busy_s, 0);
    check("rst_frame_done", frame_done_s, 0);
    check("rst_sync_err", sync_err_s, 0);
    rst_n = 1'b1;
    tick();

    // Basic frame: F8/1F pairs pack to E3 at consecutive addresses.
    clear_all(); d0 = done_s;
    cap_en_s = 1'b1; tick();
    vsync_pulse();
    add_lines(2, 8, 1'b1); model_frame(1'b0);
    send_lines();
    check("basic_busy", busy_s, 1);
    cap_en_s = 1'b0;
    vsync_pulse();
    compare_q("basic", 1'b0);
    foreach (act_s[i]) begin
      item = act_s[i];
      check("basic_pix", item[7:0], 8'hE3);
    end
    check("basic_done", done_s - d0, 1);
    check("basic_err", sync_err_s, exp_err);
    check("basic_idle", busy_s, 0);
    check("hold_addr", w_addr_s, 7);
    check("hold_data", w_data_s, 8'hE3);

    // Single snap: only the first of two frames is written.
    clear_all(); d0 = done_s;
    snap_s = 1'b1; tick(); snap_s = 1'b0;
    check("snap_arm", busy_s, 1);
    vsync_pulse();
    add_lines(2, 8, 1'b0); model_frame(1'b0);
    send_lines();
    vsync_pulse();
    check("snap_idle", busy_s, 0);
    flen.delete(); fbytes.delete();
    add_lines(2, 8, 1'b0);
    send_lines();
    vsync_pulse();
    compare_q("snap", 1'b0);
    check("snap_done", done_s - d0, 1);

    // Odd-length first line: error flag, next line still starts at addr 4.
    clear_all(); d0 = done_s;
    cap_en_s = 1'b1; tick();
    vsync_pulse();
    add_lines(1, 9, 1'b0); add_lines(1, 8, 1'b0); model_frame(1'b0);
    send_lines();
    cap_en_s = 1'b0;
    vsync_pulse();
    compare_q("odd", 1'b0);
    check("odd_err", sync_err_s, 1);

    // Overlong lines and an extra line: clipped, error, nothing at addr >= 8.
    clear_all();
    cap_en_s = 1'b1; tick();
    vsync_pulse();
    add_lines(3, 10, 1'b0); model_frame(1'b0);
    send_lines();
    cap_en_s = 1'b0;
    vsync_pulse();
    compare_q("clip", 1'b0);
    check("clip_err", sync_err_s, 1);
    begin
      int maxa;
      maxa = 0;
      foreach (act_s[i]) begin
        item = act_s[i];
        if (int'(item[22:8]) > maxa) maxa = int'(item[22:8]);
      end
      check("clip_max_addr_lt8", maxa < 8, 1);
    end

    // Reset mid-line: outputs cleared, no writes until a fresh sync.
    clear_all();
    cap_en_s = 1'b1; tick();
    vsync_pulse();
    cam_href = 1'b1;
    for (int j = 0; j < 5; j++) begin cam_data = 8'($urandom); tick(); end
    rst_n = 1'b0; cam_data = 8'($urandom); tick();
    check("mrst_w_en", w_en_s, 0);
    check("mrst_w_addr", w_addr_s, 0);
    check("mrst_w_data", w_data_s, 0);
    check("mrst_busy", busy_s, 0);
    check("mrst_err", sync_err_s, 0);
    rst_n = 1'b1;
    act_s.delete();
    for (int j = 0; j < 4; j++) begin cam_data = 8'($urandom); tick(); end
    cam_href = 1'b0;
    repeat (5) tick();
    check("mrst_no_write", act_s.size(), 0);
    check("mrst_armed", busy_s, 1);
    add_lines(2, 8, 1'b0); model_frame(1'b0);
    vsync_pulse();
    send_lines();
    cap_en_s = 1'b0;
    vsync_pulse();
    compare_q("mrst", 1'b0);

    // Continuous capture: two frames, address restarts at 0.
    clear_all(); d0 = done_s;
    cap_en_s = 1'b1; tick();
    vsync_pulse();
    add_lines(2, 8, 1'b0); model_frame(1'b0);
    send_lines();
    vsync_pulse();
    check("cont_busy", busy_s, 1);
    flen.delete(); fbytes.delete();
    add_lines(2, 8, 1'b0); model_frame(1'b0);
    send_lines();
    cap_en_s = 1'b0;
    vsync_pulse();
    compare_q("cont", 1'b0);
    check("cont_done", done_s - d0, 2);
    if (act_s.size() > 8) begin
      item = act_s[8];
      check("cont_restart", item[22:8], 0);
    end

    // Full default-size frame.
    clear_all(); d0 = done_b;
    cap_en_b = 1'b1; tick();
    vsync_pulse();
    add_lines(120, 352, 1'b0); model_frame(1'b1);
    send_lines();
    cap_en_b = 1'b0;
    vsync_pulse();
    compare_q("big", 1'b1);
    if (act_b.size() > 0) begin
      item = act_b[act_b.size() - 1];
      check("big_last_addr", item[22:8], 21119);
    end
    check("big_done", done_b - d0, 1);
    check("big_err", sync_err_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
